// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: fetches from imem at pc, hands each
// instruction to the execute stage, then resolves the next pc from the decoded
// control (halt / ret / call / conditional jump / sequential) with a small
// hardware return stack.
//
// Handshakes: imem_req is held high in FETCH until imem_ack is seen in the
// same cycle (ir_load marks that cycle); exec_start is a one-cycle pulse on the
// first EXEC cycle and the decode inputs are sampled on the edge where
// exec_done is high while in EXEC.
module fetch_sequencer #(
    parameter int A_WIDTH     = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic               imem_ack,
    output logic               ir_load,
    output logic               exec_start,
    input  logic               exec_done,
    input  logic               is_jump,
    input  logic               is_call,
    input  logic               is_ret,
    input  logic               is_halt,
    input  logic [1:0]         jump_cond,
    input  logic [A_WIDTH-1:0] jump_addr,
    input  logic               flag_z,
    input  logic               flag_s,
    input  logic               flag_o,
    input  logic               flags_we,
    output logic [A_WIDTH-1:0] pc,
    output logic               halted,
    output logic               fault,
    output logic [2:0]         state_dbg
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        HALT  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [2:0]         flags_q;       // {Z, S, O}
    logic               exec_fresh_q;  // high only in the first EXEC cycle
    logic               push;
    logic [A_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [A_WIDTH-1:0] pc_plus1;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   top_idx;
    logic               cond_taken;
    logic               stack_empty;
    logic               stack_full;

    assign pc_plus1    = pc_q + A_WIDTH'(1);
    assign push_idx    = IDX_W'(sp_q);
    assign top_idx     = IDX_W'(sp_q - SP_W'(1));
    assign stack_empty = (sp_q == SP_W'(0));
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));

    // Jump condition uses the flags as registered before the current edge.
    always_comb begin
        cond_taken = 1'b0;
        case (jump_cond)
            2'b00:   cond_taken = 1'b1;
            2'b01:   cond_taken = flags_q[2];
            2'b10:   cond_taken = !flags_q[2];
            default: cond_taken = flags_q[1] ^ flags_q[0];
        endcase
    end

    // Next-state, next-pc and stack-pointer decisions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) state_d = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    if (is_halt) begin
                        state_d = HALT;
                    end else if (is_ret) begin
                        if (stack_empty) begin
                            state_d = FAULT;
                        end else begin
                            pc_d    = stack_mem[top_idx];
                            sp_d    = sp_q - SP_W'(1);
                            state_d = FETCH;
                        end
                    end else if (is_call) begin
                        if (stack_full) begin
                            state_d = FAULT;
                        end else begin
                            push    = 1'b1;
                            pc_d    = jump_addr;
                            sp_d    = sp_q + SP_W'(1);
                            state_d = FETCH;
                        end
                    end else if (is_jump) begin
                        pc_d    = cond_taken ? jump_addr : pc_plus1;
                        state_d = FETCH;
                    end else begin
                        pc_d    = pc_plus1;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                // HALT and FAULT are terminal until reset.
                state_d = state_q;
            end
        endcase
    end

    // State, pc, stack pointer, flags and first-cycle marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            sp_q         <= '0;
            flags_q      <= 3'b000;
            exec_fresh_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            exec_fresh_q <= (state_q == FETCH) && imem_ack;
            if (flags_we) flags_q <= {flag_z, flag_s, flag_o};
        end
    end

    // Return-stack storage; only the pushed slot is ever written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
        end else if (push) begin
            stack_mem[push_idx] <= pc_plus1;
        end
    end

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign ir_load    = imem_req & imem_ack;
    assign exec_start = (state_q == EXEC) && exec_fresh_q;
    assign pc         = pc_q;
    assign halted     = (state_q == HALT);
    assign fault      = (state_q == FAULT);
    assign state_dbg  = state_q;

endmodule
